// File: rtl/fifo_rr_arbiter_if.sv
// Handshake bundle between the round-robin arbiter, its source FIFOs and the output sink.
// The master modport is the arbiter's view; the slave modport is the environment's view.
interface fifo_rr_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int N     = 4
);
    localparam int SRC_W = (N > 1) ? $clog2(N) : 1;

    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_empty;
    logic [N-1:0]       in_enable;
    logic [N-1:0]       in_rd_en;
    logic [WIDTH-1:0]   out_data;
    logic [SRC_W-1:0]   out_src;
    logic               out_valid;
    logic               out_ready;
    logic               busy;

    modport master (
        input  in_data, in_empty, in_enable, out_ready,
        output in_rd_en, out_data, out_src, out_valid, busy
    );

    modport slave (
        output in_data, in_empty, in_enable, out_ready,
        input  in_rd_en, out_data, out_src, out_valid, busy
    );
endinterface

// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter draining N FWFT FIFOs onto one registered valid/ready stream,
// granting one source for a burst of up to BURST words before rotating priority.
module fifo_rr_arbiter #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int BURST = 4
) (
    input  logic               clk,
    input  logic               srst,
    fifo_rr_arbiter_if.master  bus
);
    localparam int SRC_W = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W = $clog2(BURST + 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    state_e             state_q;
    logic [SRC_W-1:0]   grant_q;
    logic [SRC_W-1:0]   rr_ptr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   out_data_q;
    logic [SRC_W-1:0]   out_src_q;
    logic               out_valid_q;

    logic [N-1:0]       elig_s;
    logic               found_s;
    logic [SRC_W-1:0]   pick_s;
    logic [WIDTH-1:0]   heads_s [N];
    logic               head_ok_s;
    logic               pop_s;
    logic [N-1:0]       rd_en_s;

    // Index (base + offset) mod N, used both for the priority search and pointer rotation
    function automatic logic [SRC_W-1:0] wrap_idx(input logic [SRC_W-1:0] base, input int offset);
        int sum_v;
        sum_v = (int'(base) + offset) % N;
        return SRC_W'(sum_v);
    endfunction

    // Unpack the flat head-word bus and qualify each source for arbitration
    always_comb begin
        elig_s = bus.in_enable & ~bus.in_empty;
        for (int i = 0; i < N; i++) begin
            heads_s[i] = bus.in_data[i*WIDTH +: WIDTH];
        end
    end

    // First eligible source at or after rr_ptr; descending scan so the nearest offset wins
    always_comb begin
        found_s = 1'b0;
        pick_s  = rr_ptr_q;
        for (int k = N - 1; k >= 0; k--) begin
            pick_s  = elig_s[wrap_idx(rr_ptr_q, k)] ? wrap_idx(rr_ptr_q, k) : pick_s;
            found_s = found_s | elig_s[wrap_idx(rr_ptr_q, k)];
        end
    end

    // Pop qualification for the granted source; reset suppresses any pop in its cycle
    always_comb begin
        head_ok_s = !bus.in_empty[grant_q] && bus.in_enable[grant_q];
        pop_s     = (state_q == ST_GRANT) && head_ok_s && (!out_valid_q || bus.out_ready) && !srst;
    end

    // One-hot pop strobe towards the granted FIFO
    always_comb begin
        rd_en_s = '0;
        if (pop_s) begin
            rd_en_s[grant_q] = 1'b1;
        end else begin
            rd_en_s = '0;
        end
    end

    // Arbitration FSM together with the output register it feeds
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (found_s) begin
                        grant_q <= pick_s;
                        cnt_q   <= '0;
                        state_q <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (pop_s) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(BURST - 1)) begin
                            state_q  <= ST_IDLE;
                            rr_ptr_q <= wrap_idx(grant_q, 1);
                        end
                    end else if (!head_ok_s) begin
                        // Source ran dry or was masked: give up the grant early
                        state_q  <= ST_IDLE;
                        rr_ptr_q <= wrap_idx(grant_q, 1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase

            if (pop_s) begin
                out_data_q  <= heads_s[grant_q];
                out_src_q   <= grant_q;
                out_valid_q <= 1'b1;
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_rd_en  = rd_en_s;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = (state_q == ST_GRANT);
endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Self-checking bench for fifo_rr_arbiter: queue-backed FWFT sources, a cycle-level
// behavioural model of the arbitration rules and a per-source in-order scoreboard.
module tb_fifo_rr_arbiter;
    localparam int WIDTH = 32;
    localparam int N     = 4;
    localparam int BURST = 4;

    logic clk = 1'b0;
    logic srst;
    always #5 clk = ~clk;

    fifo_rr_arbiter_if #(.WIDTH(WIDTH), .N(N)) bus();
    fifo_rr_arbiter #(.WIDTH(WIDTH), .N(N), .BURST(BURST)) dut (
        .clk  (clk),
        .srst (srst),
        .bus  (bus)
    );

    // Source FIFOs: word = {source, sequence number}
    logic [WIDTH-1:0] fifo_q [N][$];
    int next_seq [N];
    int exp_seq  [N];
    logic [N-1:0] en_v;
    logic [N-1:0] hide_v;

    // Behavioural model: owner of the current burst, words taken, priority pointer, output slot
    bit              m_busy;
    int              m_owner, m_cnt, m_ptr;
    bit              m_ov;
    logic [WIDTH-1:0] m_od;
    int              m_os;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int acc_src[$];
    int acc_cyc[$];

    int single_cyc[5] = '{2, 3, 4, 5, 7};
    int bp_cyc[4]     = '{2, 8, 9, 10};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic apply_inputs();
        for (int i = 0; i < N; i++) begin
            bus.in_empty[i] = hide_v[i] || (fifo_q[i].size() == 0);
            bus.in_data[i*WIDTH +: WIDTH] = (fifo_q[i].size() > 0) ? fifo_q[i][0] : (32'hDEAD0000 | 32'(i));
        end
        bus.in_enable = en_v;
    endtask

    task automatic push_words(input int src, input int n);
        for (int k = 0; k < n; k++) begin
            fifo_q[src].push_back({8'(src), 24'(next_seq[src])});
            next_seq[src]++;
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_owner = 0; m_cnt = 0; m_ptr = 0;
        m_ov = 1'b0; m_od = '0; m_os = 0;
    endtask

    // One clock: compare at negedge, advance model, pop the FIFOs the DUT strobed
    task automatic step();
        logic [N-1:0] elig, exp_rd;
        logic [WIDTH-1:0] head, exp_word;
        bit pop, found;
        apply_inputs();
        @(negedge clk);
        elig = en_v & ~bus.in_empty;
        exp_rd = '0;
        if (!srst && m_busy && elig[m_owner] && (!m_ov || bus.out_ready)) exp_rd[m_owner] = 1'b1;
        pop = (exp_rd != '0);
        head = bus.in_data[m_owner*WIDTH +: WIDTH];
        chk("in_rd_en", bus.in_rd_en, exp_rd);
        chk("out_valid", bus.out_valid, m_ov);
        chk("busy", bus.busy, m_busy);
        if (m_ov) begin
            chk("out_data", bus.out_data, m_od);
            chk("out_src", bus.out_src, m_os);
        end
        if (m_ov && bus.out_ready && !srst) begin
            exp_word = {8'(m_os), 24'(exp_seq[m_os])};
            chk("scoreboard", bus.out_data, exp_word);
            exp_seq[m_os]++;
            acc_src.push_back(m_os);
            acc_cyc.push_back(cyc);
        end
        if (srst) begin
            if (m_ov) exp_seq[m_os]++;
            model_reset();
        end else begin
            if (!m_busy) begin
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    if (!found && elig[(m_ptr + k) % N]) begin
                        found = 1'b1; m_busy = 1'b1; m_owner = (m_ptr + k) % N; m_cnt = 0;
                    end
                end
            end else if (pop) begin
                m_cnt++;
                if (m_cnt == BURST) begin m_busy = 1'b0; m_ptr = (m_owner + 1) % N; end
            end else if (!elig[m_owner]) begin
                m_busy = 1'b0; m_ptr = (m_owner + 1) % N;
            end
            if (pop) begin m_od = head; m_os = m_owner; m_ov = 1'b1; end
            else if (m_ov && bus.out_ready) m_ov = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (bus.in_rd_en[i] && fifo_q[i].size() > 0) void'(fifo_q[i].pop_front());
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        srst = 1'b1;
        hide_v = '0; en_v = '1; bus.out_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            fifo_q[i].delete(); next_seq[i] = 0; exp_seq[i] = 0;
        end
        model_reset();
        apply_inputs();
        @(posedge clk);
        #1;
        step();
        srst = 1'b0;
        acc_src.delete(); acc_cyc.delete();
        cyc = 0;
    endtask

    initial begin
        // Reset values
        do_reset();
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_out_src", bus.out_src, 2'd0);
        chk("rst_out_data", bus.out_data, 32'd0);

        // Single source: burst of 4, one gap cycle, then the fifth word
        do_reset();
        push_words(2, 5);
        for (int t = 0; t < 12; t++) step();
        chk("single_count", acc_src.size(), 5);
        for (int k = 0; k < 5; k++) begin
            chk("single_src", (k < acc_src.size()) ? acc_src[k] : -1, 2);
            chk("single_cycle", (k < acc_cyc.size()) ? acc_cyc[k] : -1, single_cyc[k]);
        end

        // Round robin over four full sources: 0,1,2,3,0,1,2,3 with 4 words each
        do_reset();
        for (int i = 0; i < N; i++) push_words(i, 8);
        for (int t = 0; t < 45; t++) step();
        chk("rr_count", acc_src.size(), 32);
        for (int k = 0; k < 32; k++) begin
            chk("rr_order", (k < acc_src.size()) ? acc_src[k] : -1, (k / 4) % 4);
        end
        chk("rr_last_cycle", (acc_cyc.size() == 32) ? acc_cyc[31] : -1, 40);

        // Backpressure for 5 cycles mid-burst
        do_reset();
        push_words(0, 4);
        for (int t = 0; t < 3; t++) step();
        bus.out_ready = 1'b0;
        for (int t = 0; t < 5; t++) step();
        bus.out_ready = 1'b1;
        for (int t = 0; t < 6; t++) step();
        chk("bp_count", acc_src.size(), 4);
        for (int k = 0; k < 4; k++) begin
            chk("bp_cycle", (k < acc_cyc.size()) ? acc_cyc[k] : -1, bp_cyc[k]);
        end

        // Early empty ends the burst; masked source is never popped; pointer moves to 2
        do_reset();
        push_words(1, 2);
        push_words(3, 4);
        en_v = 4'b0111;
        for (int t = 0; t < 8; t++) step();
        chk("early_count", acc_src.size(), 2);
        chk("early_src", (acc_src.size() > 0) ? acc_src[0] : -1, 1);
        acc_src.delete(); acc_cyc.delete();
        push_words(0, 2);
        push_words(2, 2);
        for (int t = 0; t < 10; t++) step();
        chk("ptr_after_early", (acc_src.size() > 0) ? acc_src[0] : -1, 2);
        chk("masked_untouched", fifo_q[3].size(), 4);

        // Reset in the middle of a burst from source 2
        do_reset();
        push_words(1, 4);
        push_words(2, 4);
        for (int t = 0; t < 8; t++) step();
        srst = 1'b1;
        #1;
        chk("mid_pre_valid", bus.out_valid, 1'b1);
        chk("mid_rd_en_in_reset", bus.in_rd_en, 4'b0000);
        step();
        srst = 1'b0;
        chk("mid_post_valid", bus.out_valid, 1'b0);
        chk("mid_post_busy", bus.busy, 1'b0);
        acc_src.delete(); acc_cyc.delete();
        push_words(0, 2);
        push_words(3, 2);
        for (int t = 0; t < 8; t++) step();
        chk("mid_ptr_zero", (acc_src.size() > 0) ? acc_src[0] : -1, 0);

        // Randomised soak
        do_reset();
        for (int t = 0; t < 10000; t++) begin
            for (int i = 0; i < N; i++) begin
                if (fifo_q[i].size() < 6 && $urandom_range(2) == 0) push_words(i, 1);
                hide_v[i] = ($urandom_range(3) == 0);
                en_v[i]   = ($urandom_range(6) != 0);
            end
            bus.out_ready = ($urandom_range(9) < 7);
            srst = ($urandom_range(999) == 0);
            step();
        end
        srst = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/fifo_rr_arbiter.md
# fifo_rr_arbiter

Round-robin arbiter that drains N first-word-fall-through FIFOs onto one registered valid/ready output stream. It sits downstream of the team's FWFT FIFOs and owns their `rd_en` lines. It grants one source at a time for a burst of up to BURST words, then rotates priority. A per-source enable mask lets software configure which FIFOs take part in arbitration.

## Interface
- `WIDTH`, 32, data word width
- `N`, 4, number of source FIFOs (N >= 1)
- `BURST`, 4, maximum words popped per grant (BURST >= 1)
- `clk`  in  1  clock, all logic on posedge
- `srst`  in  1  reset, synchronous, active-high
- `in_data`  in  N*WIDTH  FWFT head words; source i occupies bits [i*WIDTH +: WIDTH]
- `in_empty`  in  N  FIFO empty flags; head word of source i is valid when `in_empty[i]`=0
- `in_enable`  in  N  arbitration mask; 0 excludes source i
- `in_rd_en`  out  N  pop strobes; at most one bit high per cycle; combinational
- `out_data`  out  WIDTH  registered output word
- `out_src`  out  $clog2(N) (min 1)  index of the source that supplied `out_data`
- `out_valid`  out  1  `out_data` holds a word
- `out_ready`  in  1  sink accepts the word this cycle
- `busy`  out  1  state is GRANT

## Operation
- The block has two states: IDLE and GRANT. Registers are `grant` (source index), `rr_ptr` (highest-priority index), `cnt` ($clog2(BURST+1) bits) and the output register.
- Eligible source: `in_enable[i]=1` and `in_empty[i]=0`.
- IDLE: if any source is eligible, the block latches the first eligible index at or after `rr_ptr` (searching upward, wrapping mod N) into `grant`, clears `cnt`, and moves to GRANT. If no source is eligible, it stays in IDLE.
- GRANT, pop condition: `pop = !in_empty[grant] && in_enable[grant] && (!out_valid || out_ready) && !srst`. `in_rd_en[grant] = pop`; every other bit is 0.
- On pop:
  - `out_data <= in_data[grant]`, `out_src <= grant`, `out_valid <= 1`, `cnt <= cnt+1`.
  - If `cnt == BURST-1`, the burst ends.
- Without a pop: if `out_valid && out_ready`, then `out_valid <= 0`. Otherwise `out_data`, `out_src` and `out_valid` hold.
- A burst ends, returning to IDLE with `rr_ptr <= (grant+1) mod N`, when either of these holds:
  - a pop with `cnt == BURST-1`;
  - a GRANT cycle where `in_empty[grant]=1` or `in_enable[grant]=0`. No pop occurs that cycle.
- Backpressure (`out_ready`=0 with `out_valid`=1) stalls the burst: the block stays in GRANT with no pop and does not end the burst.
- Output handshake: once `out_valid` is high, `out_data` and `out_src` stay stable until `out_ready` is sampled high.
- When the output register is empty or being drained, the block pops and loads a new word in that same cycle.

## Timing
- Reset values: state IDLE, `grant`=0, `rr_ptr`=0, `cnt`=0, `out_valid`=0, `out_data`=0, `out_src`=0, `busy`=0. `in_rd_en`=0 in any cycle where `srst`=1.
- Reset during a burst aborts it: any word held in the output register is dropped, and no pop occurs in the reset cycle.
- Latency: a source that becomes eligible in cycle t with the block in IDLE is granted at the edge ending cycle t. Its first pop is in cycle t+1, and `out_valid` is high in cycle t+2.
- Each burst end is followed by one IDLE cycle. With `out_ready` held at 1 and all sources non-empty, throughput is BURST words per BURST+1 cycles.
- Priority is fair: every source that stays eligible is granted within N bursts.
- N=1: `rr_ptr` stays 0 and the block still passes through one IDLE cycle between bursts.

## Test plan
- Single source: WIDTH=32, N=4, BURST=4, source 2 holds {A,B,C,D,E}, `out_ready`=1. Required: `out_src`=2 for A..D on consecutive cycles, then one gap cycle, then E. `in_rd_en` is never high for any source other than 2.
- Round-robin: all 4 sources hold 8 words and `out_ready`=1. Required grant order 0,1,2,3,0,1,2,3, with 4 words per grant and one idle cycle between grants.
- Backpressure: `out_ready`=0 for 5 cycles in the middle of a burst. Required: `out_data`/`out_src` stable, `in_rd_en`=0, `cnt` frozen. After release the burst resumes with no loss or duplication.
- Early empty and mask: source 1 holds 2 words, and `in_enable[3]`=0 while source 3 holds data. Required: the burst from source 1 ends after 2 words, `rr_ptr` becomes 2, and source 3 is never popped.
- Reset mid-burst: assert `srst` for 1 cycle while `out_valid`=1 in GRANT. Required: the next cycle shows `out_valid`=0, state IDLE, `rr_ptr`=0, and `in_rd_en`=0 during the reset cycle.
- Scoreboard over 10k random cycles with random `in_empty`, `in_enable` and `out_ready`. Required: every popped word appears exactly once and in order per source, and `in_rd_en` is never asserted while `in_empty` is 1.
